timestep_sequencer: RTL and testbench

//  Parametrised timestep controller for the SNN core. Advances the encoder and neuron

---
 rtl/snn_pkg.sv | 14 +
 rtl/tick_divider.sv | 28 ++
 rtl/timestep_sequencer.sv | 111 +++++++++++
 tb/tb_timestep_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN core definitions: timestep sequencer states and default stamp width.
package snn_pkg;

  localparam int unsigned STAMP_W_DEF = 4;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_DRAIN = 3'd1,
    S_ADV_E = 3'd2,
    S_ADV_N = 3'd3,
    S_LEAK  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the wrap cycle on tick_c.
module tick_divider #(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  output logic tick_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clear || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timestep_sequencer.sv
// Timestep controller: advances encoder and neuron stamps once encoding is done and
// the core has drained, optionally gated by a fixed-period tick and followed by a leak pass.
module timestep_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned STAMP_W  = STAMP_W_DEF,
  parameter int unsigned N_GROUP  = 16,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clear,
  input  logic               run_mode,
  input  logic               leak_en,
  input  logic               encode_finish,
  input  logic               fifo_empty,
  input  logic [N_GROUP-1:0] group_empty,
  input  logic               ctrl_idle,
  input  logic               leak_ack,
  output logic [STAMP_W-1:0] encode_stamp,
  output logic [STAMP_W-1:0] neuron_stamp,
  output logic               encode_event,
  output logic               tref_event,
  output logic               leak_req,
  output logic               busy,
  output logic               step_overrun
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic       enc_cap;
  logic       tick_pend;
  logic       tick_c;
  logic       drain_ok;
  logic       enter_adv_e;

  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_divider (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (clear),
    .tick_c (tick_c)
  );

  // Next-state logic; enter_adv_e marks the single cycle that commits a step.
  always_comb begin
    state_nxt   = state;
    drain_ok    = fifo_empty & (&group_empty) & ctrl_idle;
    enter_adv_e = 1'b0;
    unique case (state)
      S_WAIT:  if (enc_cap && (!run_mode || tick_pend)) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok) begin
        state_nxt   = S_ADV_E;
        enter_adv_e = 1'b1;
      end
      S_ADV_E: state_nxt = S_ADV_N;
      S_ADV_N: state_nxt = leak_en ? S_LEAK : S_WAIT;
      S_LEAK:  if (leak_ack) state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  // State, capture flags and registered outputs; stamps move on the entry edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_WAIT;
      enc_cap      <= 1'b0;
      tick_pend    <= 1'b0;
      encode_stamp <= '0;
      neuron_stamp <= '1;
      encode_event <= 1'b0;
      tref_event   <= 1'b0;
      leak_req     <= 1'b0;
      busy         <= 1'b0;
      step_overrun <= 1'b0;
    end else if (clear) begin
      state        <= S_WAIT;
      enc_cap      <= 1'b0;
      tick_pend    <= 1'b0;
      encode_stamp <= '0;
      neuron_stamp <= '1;
      encode_event <= 1'b0;
      tref_event   <= 1'b0;
      leak_req     <= 1'b0;
      busy         <= 1'b0;
      step_overrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      // A capture coinciding with step entry survives for the following step.
      enc_cap      <= encode_finish | (enc_cap & ~enter_adv_e);
      tick_pend    <= tick_c | (tick_pend & ~(enter_adv_e & run_mode));
      if ((encode_finish & enc_cap & ~enter_adv_e) | (tick_c & tick_pend)) begin
        step_overrun <= 1'b1;
      end
      if (enter_adv_e) begin
        encode_stamp <= encode_stamp + STAMP_W'(1);
      end
      if (state == S_ADV_E) begin
        neuron_stamp <= neuron_stamp + STAMP_W'(1);
      end
      encode_event <= enter_adv_e;
      tref_event   <= enter_adv_e;
      leak_req     <= (state_nxt == S_LEAK);
      busy         <= (state_nxt != S_WAIT);
    end
  end

endmodule

// File: tb/tb_timestep_sequencer.sv
// Directed bench: a slow-tick instance covers event-driven steps, a TICK_DIV=8 instance covers timer mode.
module tb_timestep_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        clear;
  logic        run_mode;
  logic        leak_en;
  logic        encode_finish;
  logic        fifo_empty;
  logic [15:0] group_empty;
  logic        ctrl_idle;
  logic        leak_ack;

  logic [3:0]  e_enc, e_neu, t_enc, t_neu;
  logic        e_eev, e_tref, e_lreq, e_busy, e_ovr;
  logic        t_eev, t_tref, t_lreq, t_busy, t_ovr;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_e;
  logic [3:0] exp_n;

  timestep_sequencer #(.STAMP_W(4), .N_GROUP(16), .TICK_DIV(1024), .CNT_W(10)) u_evt (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .run_mode(run_mode), .leak_en(leak_en),
    .encode_finish(encode_finish), .fifo_empty(fifo_empty), .group_empty(group_empty),
    .ctrl_idle(ctrl_idle), .leak_ack(leak_ack), .encode_stamp(e_enc), .neuron_stamp(e_neu),
    .encode_event(e_eev), .tref_event(e_tref), .leak_req(e_lreq), .busy(e_busy),
    .step_overrun(e_ovr)
  );

  timestep_sequencer #(.STAMP_W(4), .N_GROUP(16), .TICK_DIV(8), .CNT_W(3)) u_tmr (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .run_mode(run_mode), .leak_en(leak_en),
    .encode_finish(encode_finish), .fifo_empty(fifo_empty), .group_empty(group_empty),
    .ctrl_idle(ctrl_idle), .leak_ack(leak_ack), .encode_stamp(t_enc), .neuron_stamp(t_neu),
    .encode_event(t_eev), .tref_event(t_tref), .leak_req(t_lreq), .busy(t_busy),
    .step_overrun(t_ovr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_finish();
    encode_finish = 1'b1;
    tick();
    encode_finish = 1'b0;
  endtask

  task automatic chk_evt_stamps(input string tag);
    chk({tag, "_enc"}, 32'(e_enc), 32'(exp_e));
    chk({tag, "_neu"}, 32'(e_neu), 32'(exp_n));
  endtask

  initial begin
    RST_N = 1'b0; clear = 1'b0; run_mode = 1'b0; leak_en = 1'b0; encode_finish = 1'b0;
    fifo_empty = 1'b1; group_empty = '1; ctrl_idle = 1'b1; leak_ack = 1'b0;
    exp_e = 4'd0; exp_n = 4'd15;
    tick(3);
    chk("rst_enc", 32'(e_enc), 32'd0);
    chk("rst_neu", 32'(e_neu), 32'd15);
    chk("rst_outs", 32'({e_eev, e_tref, e_lreq, e_busy, e_ovr}), 32'd0);
    chk("rst_tmr_neu", 32'(t_neu), 32'd15);
    RST_N = 1'b1;

    // Basic event-mode step
    tick(10);
    pulse_finish();
    chk("t1_wait_busy", 32'(e_busy), 32'd0);
    tick();
    chk("t1_drain_busy", 32'(e_busy), 32'd1);
    chk_evt_stamps("t1_drain");
    tick();
    exp_e = 4'd1;
    chk_evt_stamps("t1_adve");
    chk("t1_events", 32'({e_eev, e_tref}), 32'b11);
    tick();
    exp_n = 4'd0;
    chk_evt_stamps("t1_advn");
    chk("t1_events_off", 32'({e_eev, e_tref}), 32'b00);
    tick();
    chk("t1_idle", 32'(e_busy), 32'd0);

    // Group 5 not drained holds the step in S_DRAIN
    group_empty = 16'hFFDF;
    pulse_finish();
    tick();
    tick(20);
    chk("t2_hold_busy", 32'(e_busy), 32'd1);
    chk_evt_stamps("t2_hold");
    group_empty = '1;
    tick();
    exp_e = exp_e + 4'd1;
    chk_evt_stamps("t2_adve");
    tick();
    exp_n = exp_n + 4'd1;
    chk_evt_stamps("t2_advn");
    tick();

    // Sixteen steps wrap both stamps
    for (int i = 0; i < 16; i++) begin
      pulse_finish();
      tick(3);
      exp_e = exp_e + 4'd1;
      exp_n = exp_n + 4'd1;
      chk_evt_stamps("t3_step");
      tick();
    end
    chk("t3_no_ovr", 32'(e_ovr), 32'd0);

    // encode_finish on the S_ADV_E entry edge is kept for the next step
    pulse_finish();
    tick();
    encode_finish = 1'b1;
    tick();
    encode_finish = 1'b0;
    exp_e = exp_e + 4'd1;
    chk("sim_ovr", 32'(e_ovr), 32'd0);
    chk_evt_stamps("sim_adve");
    tick(2);
    exp_n = exp_n + 4'd1;
    chk("sim_wait", 32'(e_busy), 32'd0);
    tick();
    chk("sim_redrain", 32'(e_busy), 32'd1);
    tick(2);
    exp_e = exp_e + 4'd1;
    exp_n = exp_n + 4'd1;
    chk_evt_stamps("sim_step2");
    tick();
    chk("sim_ovr2", 32'(e_ovr), 32'd0);

    // Leak phase with a capture held across it
    leak_en = 1'b1;
    pulse_finish();
    tick(3);
    exp_e = exp_e + 4'd1;
    exp_n = exp_n + 4'd1;
    chk_evt_stamps("t5_advn");
    chk("t5_lreq_pre", 32'(e_lreq), 32'd0);
    tick();
    chk("t5_lreq_on", 32'({e_lreq, e_busy}), 32'b11);
    pulse_finish();
    tick(2);
    chk("t5_lreq_hold", 32'(e_lreq), 32'd1);
    chk_evt_stamps("t5_leak");
    leak_ack = 1'b1;
    tick();
    leak_ack = 1'b0;
    leak_en = 1'b0;
    chk("t5_lreq_off", 32'({e_lreq, e_busy}), 32'b00);
    tick();
    chk("t5_redrain", 32'(e_busy), 32'd1);
    tick();
    exp_e = exp_e + 4'd1;
    chk_evt_stamps("t5_adve2");
    tick(2);
    exp_n = exp_n + 4'd1;
    chk_evt_stamps("t5_done");
    chk("t5_idle", 32'(e_busy), 32'd0);
    leak_ack = 1'b1;
    tick();
    leak_ack = 1'b0;
    chk("t5_stray_ack", 32'({e_lreq, e_busy}), 32'b00);

    // Timer mode on the TICK_DIV=8 instance
    RST_N = 1'b0;
    run_mode = 1'b1;
    tick();
    chk("t4_rst", 32'({t_enc, t_busy, t_ovr}), 32'd0);
    RST_N = 1'b1;
    tick(2);
    pulse_finish();
    tick(4);
    chk("t4_c7_busy", 32'(t_busy), 32'd0);
    chk("t4_c7_enc", 32'(t_enc), 32'd0);
    tick();
    chk("t4_c8_busy", 32'(t_busy), 32'd0);
    tick();
    chk("t4_c9_busy", 32'(t_busy), 32'd1);
    tick();
    chk("t4_c10_enc", 32'(t_enc), 32'd1);
    chk("t4_c10_ev", 32'({t_eev, t_tref}), 32'b11);
    tick();
    chk("t4_c11_neu", 32'(t_neu), 32'd0);
    tick();
    chk("t4_c12_idle", 32'({t_busy, t_ovr}), 32'b00);
    tick(11);
    chk("t4_c23_ovr", 32'(t_ovr), 32'd0);
    tick();
    chk("t4_c24_ovr", 32'(t_ovr), 32'd1);
    tick(10);
    chk("t4_ovr_sticky", 32'(t_ovr), 32'd1);
    chk("t4_stamps", 32'({t_enc, t_neu}), 32'h10);

    // Async reset mid-step, then sync clear in S_LEAK
    run_mode = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    pulse_finish();
    tick(4);
    chk("t6_step", 32'({e_enc, e_neu}), 32'h10);
    group_empty = 16'hFFDF;
    pulse_finish();
    tick();
    pulse_finish();
    chk("t6_enc_ovr", 32'({e_ovr, e_busy}), 32'b11);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t6_async", 32'({e_enc, e_neu, e_busy, e_ovr}), 32'({4'd0, 4'd15, 1'b0, 1'b0}));
    tick();
    RST_N = 1'b1;
    group_empty = '1;
    leak_en = 1'b1;
    pulse_finish();
    tick(4);
    chk("t6_leak", 32'({e_enc, e_neu, e_lreq}), 32'({4'd1, 4'd0, 1'b1}));
    clear = 1'b1;
    #3;
    chk("t6_clr_sync", 32'({e_lreq, e_busy}), 32'b11);
    tick();
    clear = 1'b0;
    leak_en = 1'b0;
    chk("t6_clr", 32'({e_enc, e_neu, e_lreq, e_busy, e_ovr}), 32'({4'd0, 4'd15, 3'b000}));
    tick(3);
    chk("t6_clr_idle", 32'(e_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
